md_rotate_unit: RTL
===================

Name: md_rotate_unit

Overview:
- Execution stage directly downstream of the MD/MDS format decoder.
- Executes the six 64-bit rotate-and-mask instructions: rldicl, rldicr, rldic, rldimi, rldcl, rldcr.
- Inputs are the decoder's raw field outputs plus register-file operands. Produces the RA writeback value and an optional CR0 update.
- Two-stage valid/ready pipeline: stage 1 rotates, stage 2 masks, merges and computes CR0.

Parameters:
- dataWidth, 64, operand/result width
- regWidth, 5, register index width
- immWidth, 6, mb/me field width
- opWidth, 3, operation select width

Ports:
- clock_i  in  1  clock; all state changes on rising edge
- reset_i  in  1  asynchronous, active-high reset
- valid_i  in  1  input op present
- ready_o  out  1  unit can accept input this cycle
- op_i  in  3  0 rldicl, 1 rldicr, 2 rldic, 3 rldimi, 4 rldcl, 5 rldcr; 6 and 7 illegal
- rs_i  in  64  RS operand value
- ra_i  in  64  RA operand value (merge source for rldimi)
- rb_i  in  64  RB operand value (shift source for rldcl/rldcr)
- dest_i  in  5  RA index, passed through
- shLow_i  in  5  sh[0:4] (instruction bits 16:20)
- shHigh_i  in  1  sh[5] (instruction bit 30)
- imm_i  in  6  mb/me field (instruction bits 21:26)
- rc_i  in  1  record bit
- xerSo_i  in  1  XER[SO], sampled with the op
- valid_o  out  1  result present
- ready_i  in  1  consumer accepts result
- result_o  out  64  RA writeback value
- dest_o  out  5  RA index
- crValid_o  out  1  CR0 update required (Rc=1)
- cr0_o  out  4  LT, GT, EQ, SO
- illegal_o  out  1  op was 6 or 7; result_o forced to 0

Behaviour:
- Bit numbering: bit 0 is the MSB (ISA convention).
- Field reassembly:
  - sh = {shHigh_i, shLow_i}
  - mbe = {imm_i[5], imm_i[0:4]}
- Shift amount n: sh for ops 0-3; rb_i[58:63] for ops 4-5.
- Rotation: rot = rotl64(rs_i, n).
- mask(x,y):
  - x<=y: ones in bits x..y.
  - x>y (wrap): ones in x..63 and 0..y.
- Mask per op:
  - rldicl, rldcl: mask(mbe,63)
  - rldicr, rldcr: mask(0,mbe)
  - rldic, rldimi: mask(mbe,63-sh)
- Result:
  - rldimi: (rot & m) | (ra_i & ~m)
  - all other legal ops: rot & m
- CR0 (Rc=1 only; otherwise crValid_o=0 and cr0_o=0):
  - LT = result is negative (signed)
  - GT = result is positive, nonzero
  - EQ = result is zero
  - SO = xerSo_i
- Pipeline:
  - Stage 1 registers rot, m, ra, dest, rc, so, illegal.
  - Stage 2 registers all outputs.
  - Latency is exactly 2 cycles from the input handshake to valid_o when not stalled.
  - Throughput is 1 op/cycle.
- Handshake:
  - Input transfer occurs when valid_i & ready_o.
  - Output transfer occurs when valid_o & ready_i.
  - Stage 2 loads when empty or ready_i=1.
  - Stage 1 loads when empty or stage 2 loads.
  - ready_o = stage 1 empty OR stage 2 loads this cycle (combinational from ready_i).
- Stall: all outputs hold stable while valid_o=1 and ready_i=0. No op is dropped or duplicated.
- Simultaneous events: with both stages full and ready_i=1 in the same cycle, stage 2 retires, stage 1 advances and a new input is accepted.
- Reset: asserting reset_i at any time, including mid-stall, immediately clears both stage valids and all outputs to 0.
  - ready_o is 1 after reset.
  - In-flight ops are discarded.
- Illegal ops: flow through the pipeline as normal, with illegal_o=1, result_o=0 and crValid_o=0.

Decomposition:
- Shared package md_pkg:
  - op encodings OP_RLDICL..OP_RLDCR
  - dataWidth and regWidth constants
  - CR0 bit positions
- Sub-module md_mask_gen: combinational, inputs x[6] and y[6], output mask[64], with the wrap rule above. It is instantiated once in stage 1.

Test Plan:
- rldicl rs=0x8000000000000001, sh=1, mbe=0, Rc=1 → result 0x0000000000000003, cr0=GT (0100), valid_o exactly 2 cycles after acceptance.
- rldicr rs=0x123456789ABCDEF0, sh=0, mbe=31 → result 0x1234567800000000.
- rldimi ra=0xFFFFFFFFFFFFFFFF, rs=0, sh=16, mbe=32 → result 0xFFFFFFFF0000FFFF. Wrap case: rs=~0, ra=0, sh=8, mbe=60 → result 0xFFFFFFFFFFFFFF0F.
- rldcl rs=0x1, rb=0xFFFFFFFFFFFFFFC7 (n=7), mbe=0, Rc=1, xerSo=1 → result 0x80, cr0=0101.
- Backpressure: issue 3 back-to-back ops with ready_i low for 3 cycles → output holds op 1, ready_o drops once stage 1 fills; on release, ops 1-3 exit in order, none lost.
- Reset asserted with both stages full → valid_o=0 and result_o=0 immediately; op 6 → illegal_o=1, result_o=0.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the MD/MDS rotate-and-mask execution unit.
//   - operand, register-index, immediate and op-select widths
//   - op encodings driven by the decoder (values 6 and 7 are illegal)
//   - CR0 bit positions within the 4-bit cr0 field (LT, GT, EQ, SO from MSB)
//   - rotl64 helper
package md_pkg;

  localparam int unsigned dataWidth = 64;
  localparam int unsigned regWidth  = 5;
  localparam int unsigned immWidth  = 6;
  localparam int unsigned opWidth   = 3;

  typedef enum logic [opWidth-1:0] {
    OP_RLDICL = 3'd0,
    OP_RLDICR = 3'd1,
    OP_RLDIC  = 3'd2,
    OP_RLDIMI = 3'd3,
    OP_RLDCL  = 3'd4,
    OP_RLDCR  = 3'd5
  } md_op_e;

  localparam int unsigned Cr0Lt = 3;
  localparam int unsigned Cr0Gt = 2;
  localparam int unsigned Cr0Eq = 1;
  localparam int unsigned Cr0So = 0;

  // Rotate left by n: the upper half of the doubled word shifted left.
  function automatic logic [dataWidth-1:0] rotl64(input logic [dataWidth-1:0] x,
                                                  input logic [immWidth-1:0]  n);
    logic [2*dataWidth-1:0] dbl;
    dbl = {x, x} << n;
    return dbl[2*dataWidth-1:dataWidth];
  endfunction

endpackage

// File: rtl/md_rotate_unit_if.sv
// Handshake and payload bundle of the rotate unit.
//   Input side : valid_i/ready_o handshake, op_i, rs_i, ra_i, rb_i, dest_i, shLow_i,
//                shHigh_i, imm_i, rc_i, xerSo_i
//   Output side: valid_o/ready_i handshake, result_o, dest_o, crValid_o, cr0_o, illegal_o
// Modport slave is the unit; modport master is the producer/consumer around it.
interface md_rotate_unit_if;
  import md_pkg::*;

  logic                 valid_i;
  logic                 ready_o;
  logic [opWidth-1:0]   op_i;
  logic [dataWidth-1:0] rs_i;
  logic [dataWidth-1:0] ra_i;
  logic [dataWidth-1:0] rb_i;
  logic [regWidth-1:0]  dest_i;
  logic [4:0]           shLow_i;
  logic                 shHigh_i;
  logic [immWidth-1:0]  imm_i;
  logic                 rc_i;
  logic                 xerSo_i;

  logic                 valid_o;
  logic                 ready_i;
  logic [dataWidth-1:0] result_o;
  logic [regWidth-1:0]  dest_o;
  logic                 crValid_o;
  logic [3:0]           cr0_o;
  logic                 illegal_o;

  modport slave (
    input  valid_i, op_i, rs_i, ra_i, rb_i, dest_i, shLow_i, shHigh_i, imm_i, rc_i, xerSo_i,
    input  ready_i,
    output ready_o,
    output valid_o, result_o, dest_o, crValid_o, cr0_o, illegal_o
  );

  modport master (
    output valid_i, op_i, rs_i, ra_i, rb_i, dest_i, shLow_i, shHigh_i, imm_i, rc_i, xerSo_i,
    output ready_i,
    input  ready_o,
    input  valid_o, result_o, dest_o, crValid_o, cr0_o, illegal_o
  );

endinterface

// File: rtl/md_mask_gen.sv
// Combinational rotate mask generator.
//   x    : first one-bit, big-endian bit index (bit 0 = MSB)
//   y    : last one-bit, big-endian bit index
//   mask : ones in x..y when x <= y, otherwise ones in x..63 and 0..y (wrap)
module md_mask_gen
  import md_pkg::*;
(
  input  logic [immWidth-1:0]  x,
  input  logic [immWidth-1:0]  y,
  output logic [dataWidth-1:0] mask
);

  always_comb begin
    logic [immWidth-1:0] isa;
    mask = '0;
    for (int i = 0; i < dataWidth; i++) begin
      // Vector bit i carries big-endian bit 63-i.
      isa = immWidth'(dataWidth - 1 - i);
      if (x <= y) begin
        mask[i] = (isa >= x) && (isa <= y);
      end else begin
        mask[i] = (isa >= x) || (isa <= y);
      end
    end
  end

endmodule

// File: rtl/md_rotate_unit.sv
// Two-stage rotate-and-mask unit for rldicl, rldicr, rldic, rldimi, rldcl, rldcr.
//   clock_i : clock, rising edge
//   reset_i : asynchronous active-high reset, clears both stages
//   bus     : slave side of md_rotate_unit_if (input op handshake, result handshake)
// Stage 1 rotates and builds the mask; stage 2 masks, merges and derives CR0.
module md_rotate_unit
  import md_pkg::*;
(
  input logic            clock_i,
  input logic            reset_i,
  md_rotate_unit_if.slave bus
);

  // Decode and stage-1 datapath.
  logic [immWidth-1:0]  sh, mbe, shift_n, mask_x, mask_y;
  logic                 reg_shift, op_illegal, op_insert;
  logic [dataWidth-1:0] rot, mask;

  assign sh  = {bus.shHigh_i, bus.shLow_i};
  // mb/me field is stored rotated: its last bit is the most significant.
  assign mbe = {bus.imm_i[0], bus.imm_i[immWidth-1:1]};

  assign reg_shift  = (bus.op_i == OP_RLDCL) || (bus.op_i == OP_RLDCR);
  assign op_insert  = (bus.op_i == OP_RLDIMI);
  assign op_illegal = bus.op_i[2] & bus.op_i[1];

  // Only the low six bits of RB form the shift count.
  logic unused_rb;
  assign unused_rb = ^bus.rb_i[dataWidth-1:immWidth];

  assign shift_n = reg_shift ? bus.rb_i[immWidth-1:0] : sh;
  assign rot     = rotl64(bus.rs_i, shift_n);

  always_comb begin
    mask_x = mbe;
    mask_y = immWidth'(dataWidth - 1);
    case (bus.op_i)
      OP_RLDICL, OP_RLDCL: begin
        mask_x = mbe;
        mask_y = immWidth'(dataWidth - 1);
      end
      OP_RLDICR, OP_RLDCR: begin
        mask_x = '0;
        mask_y = mbe;
      end
      OP_RLDIC, OP_RLDIMI: begin
        mask_x = mbe;
        mask_y = immWidth'(dataWidth - 1) - sh;
      end
      default: ;
    endcase
  end

  md_mask_gen u_mask_gen (
    .x    (mask_x),
    .y    (mask_y),
    .mask (mask)
  );

  // Stage registers.
  logic                 s1_valid_q, s1_rc_q, s1_so_q, s1_illegal_q, s1_insert_q;
  logic [dataWidth-1:0] s1_rot_q, s1_mask_q, s1_ra_q;
  logic [regWidth-1:0]  s1_dest_q;

  logic                 valid_q, cr_valid_q, illegal_q;
  logic [dataWidth-1:0] result_q;
  logic [regWidth-1:0]  dest_q;
  logic [3:0]           cr0_q;

  logic s1_load, s2_load;

  assign s2_load     = ~valid_q | bus.ready_i;
  assign s1_load     = ~s1_valid_q | s2_load;
  assign bus.ready_o = s1_load;

  // Stage-2 datapath.
  logic [dataWidth-1:0] rot_masked, result_d;
  logic                 cr_valid_d;
  logic [3:0]           cr0_d;

  always_comb begin
    rot_masked = s1_rot_q & s1_mask_q;
    result_d   = s1_insert_q ? (rot_masked | (s1_ra_q & ~s1_mask_q)) : rot_masked;
    if (s1_illegal_q) begin
      result_d = '0;
    end
    cr_valid_d = s1_rc_q & ~s1_illegal_q;
    cr0_d      = '0;
    if (cr_valid_d) begin
      cr0_d[Cr0Lt] = result_d[dataWidth-1];
      cr0_d[Cr0Gt] = ~result_d[dataWidth-1] & (|result_d);
      cr0_d[Cr0Eq] = ~(|result_d);
      cr0_d[Cr0So] = s1_so_q;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      s1_valid_q   <= 1'b0;
      s1_rot_q     <= '0;
      s1_mask_q    <= '0;
      s1_ra_q      <= '0;
      s1_dest_q    <= '0;
      s1_rc_q      <= 1'b0;
      s1_so_q      <= 1'b0;
      s1_illegal_q <= 1'b0;
      s1_insert_q  <= 1'b0;
    end else if (s1_load) begin
      s1_valid_q <= bus.valid_i;
      if (bus.valid_i) begin
        s1_rot_q     <= rot;
        s1_mask_q    <= mask;
        s1_ra_q      <= bus.ra_i;
        s1_dest_q    <= bus.dest_i;
        s1_rc_q      <= bus.rc_i;
        s1_so_q      <= bus.xerSo_i;
        s1_illegal_q <= op_illegal;
        s1_insert_q  <= op_insert;
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q    <= 1'b0;
      result_q   <= '0;
      dest_q     <= '0;
      cr_valid_q <= 1'b0;
      cr0_q      <= '0;
      illegal_q  <= 1'b0;
    end else if (s2_load) begin
      valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        result_q   <= result_d;
        dest_q     <= s1_dest_q;
        cr_valid_q <= cr_valid_d;
        cr0_q      <= cr0_d;
        illegal_q  <= s1_illegal_q;
      end
    end
  end

  assign bus.valid_o   = valid_q;
  assign bus.result_o  = result_q;
  assign bus.dest_o    = dest_q;
  assign bus.crValid_o = cr_valid_q;
  assign bus.cr0_o     = cr0_q;
  assign bus.illegal_o = illegal_q;

endmodule
